pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Produces the stall, hold, bubble and flush controls for the 5-stage pipe: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Drives the ID/EX register's stall (bubble) input, which zeroes EX/WB control.
//  Detects load-use hazards, freezes the pipe while data memory is busy and flushes wrong-path instructions on taken branches.
//  Also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.
// PARAMETERS
//  REG_W        5    register-specifier width
//  CNT_W        16   stall_cycles width
//  MEM_TIMEOUT  255  max consecutive wait cycles before mem_err; range 1..2^CNT_W-1
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous reset, active-high
//  id_rA, id_rB    in   REG_W  source specifiers of the instruction in ID
//  id_useA, id_useB in  1      ID instruction actually reads rA / rB
//  ex_rD           in   REG_W  destination of the instruction in EX
//  ex_is_load      in   1      EX instruction is a load
//  ex_branch_taken in   1      EX resolved a taken branch/jump
//  mem_req         in   1      MEM stage has an access outstanding
//  mem_ready       in   1      data memory completes the access this cycle
//  pc_stall        out  1      hold PC
//  ifid_stall      out  1      hold IF/ID
//  ifid_flush      out  1      zero IF/ID (wrong path)
//  idex_bubble     out  1      ID/EX captures a bubble (ctrl <= 0)
//  idex_hold       out  1      ID/EX keeps its contents
//  exmem_hold      out  1      EX/MEM keeps its contents
//  memwb_bubble    out  1      MEM/WB captures a bubble
//  stall_cycles    out  CNT_W  count of cycles with pc_stall=1, saturating
//  mem_err         out  1      sticky: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Derived terms:
//   freeze   = mem_req & ~mem_ready
//   load_use = ex_is_load & ex_rD != 0 &
//              ((id_useA & id_rA == ex_rD) | (id_useB & id_rB == ex_rD))
//   flush    = ex_branch_taken & ~freeze
//   lu_eff   = load_use & ~flush & ~freeze   (the flush wins: ID holds a wrong-path instruction)
//  Outputs are combinational, zero-latency, same cycle as their causes:
//   pc_stall = ifid_stall = freeze | lu_eff
//   idex_hold = exmem_hold = memwb_bubble = freeze
//   idex_bubble = lu_eff | flush
//   ifid_flush = flush
//  Freeze priority:
//   - While freeze=1, flush and bubble outputs are 0 and the whole pipe holds.
//   - A taken branch frozen in EX takes effect on the first cycle freeze drops.
//  Load-use is a one-cycle stall: next cycle the load is in MEM and EX holds a bubble.
//  FSM (state register only; outputs above do not depend on it):
//   - RUN: freeze -> WAIT with wait_cnt <= 1.
//   - WAIT: mem_ready or ~mem_req -> RUN with wait_cnt <= 0; otherwise wait_cnt++.
//   - WAIT: wait_cnt == MEM_TIMEOUT while still frozen -> mem_err <= 1. Stay in WAIT and keep freezing.
//  stall_cycles increments on every cycle with pc_stall=1 and holds at all-ones.
//  mem_err clears only on rst.
//  Reset:
//   - State RUN; wait_cnt, stall_cycles and mem_err are 0.
//   - While rst=1, all stall/hold/bubble/flush outputs are forced to 0.
//   - Reset mid-WAIT abandons the wait immediately.
//  Register 0 is hardwired and never causes a hazard.
// STRUCTURE
//  Shared pipe_pkg: REG_W, REG_ZERO, and the FSM state encoding (RUN=1'b0, WAIT=1'b1).
//  One sub-module, sat_counter (width param, en, clr, q, saturates), used for stall_cycles.
//  The wait timer stays inline.
// TESTING
//  1. ex_is_load=1, ex_rD=5, id_rA=5, id_useA=1 for 1 cycle
//     -> pc_stall=ifid_stall=idex_bubble=1 that cycle only; stall_cycles=1.
//  2. Same as 1 but ex_rD=0, or id_useA=0
//     -> every output 0.
//  3. Load-use plus ex_branch_taken=1 in the same cycle
//     -> ifid_flush=idex_bubble=1, pc_stall=0.
//  4. mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1
//     -> freeze outputs=1 for exactly 3 cycles, 0 on the ready cycle; stall_cycles=3; state back to RUN.
//  5. MEM_TIMEOUT=4, mem_req=1, mem_ready never asserts
//     -> mem_err rises after the 4th wait cycle and stays 1 after mem_ready; cleared by rst.
//  6. Branch taken during freeze; rst pulsed mid-WAIT
//     -> flush fires on the release cycle; after rst all outputs and counters are 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and hazard-controller FSM encoding.
// Types only; no logic, no latency, no flow control.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/hold/bubble/flush control for the 5-stage pipe plus wait-timeout monitor.
// Control outputs are combinational (zero latency); stall_cycles and mem_err are registered.
// A busy data memory freezes every stage; load-use stalls PC/IF/ID for one cycle.
module pipe_hazard_ctrl #(
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rA,
  input  logic [REG_W-1:0] id_rB,
  input  logic             id_useA,
  input  logic             id_useB,
  input  logic [REG_W-1:0] ex_rD,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  import pipe_pkg::*;

  hz_state_t        state;
  logic [CNT_W-1:0] wait_cnt;

  logic freeze;
  logic hit_a;
  logic hit_b;
  logic load_use;
  logic flush;
  logic lu_eff;
  logic active;

  assign freeze   = mem_req & ~mem_ready;
  assign hit_a    = id_useA & (id_rA == ex_rD);
  assign hit_b    = id_useB & (id_rB == ex_rD);
  assign load_use = ex_is_load & (ex_rD != REG_W'(0)) & (hit_a | hit_b);
  // A taken branch makes the ID instruction wrong-path, so its load-use stall is moot.
  assign flush    = ex_branch_taken & ~freeze;
  assign lu_eff   = load_use & ~flush & ~freeze;
  assign active   = ~rst;

  assign pc_stall     = active & (freeze | lu_eff);
  assign ifid_stall   = active & (freeze | lu_eff);
  assign ifid_flush   = active & flush;
  assign idex_bubble  = active & (lu_eff | flush);
  assign idex_hold    = active & freeze;
  assign exmem_hold   = active & freeze;
  assign memwb_bubble = active & freeze;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (pc_stall),
    .q   (stall_cycles)
  );

  // wait_cnt parks at MEM_TIMEOUT once the error fires; the pipe keeps freezing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (!freeze) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
